// File: rtl/im_window_gen_if.sv
// im_window_gen_if: pixel-in / window-out bundle of the window generator.
// master = window generator, slave = pixel source + convolutor side.
interface im_window_gen_if #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int DATA_SIZE = 8
);
  localparam int WRW = $clog2(IMG_H/2);
  localparam int WCW = $clog2(IMG_W/2);

  logic                      pxVld;
  logic                      pxRdy;
  logic [DATA_SIZE-1:0]      px;
  logic                      imVld;
  logic                      imRdy;
  logic [36*DATA_SIZE-1:0]   im;
  logic [WRW-1:0]            winRow;
  logic [WCW-1:0]            winCol;
  logic                      frmDone;

  modport master (
    input  pxVld, px, imRdy,
    output pxRdy, imVld, im, winRow, winCol, frmDone
  );

  modport slave (
    output pxVld, px, imRdy,
    input  pxRdy, imVld, im, winRow, winCol, frmDone
  );
endinterface

// File: rtl/im_window_gen.sv
// im_window_gen: buffers 6 raster rows, emits 6x6 stride-2 windows.
// Ports: clk, rst (async, active-low), bus (pixel in, im window out).
module im_window_gen #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int DATA_SIZE = 8
) (
  input  logic clk,
  input  logic rst,
  im_window_gen_if.master bus
);
  localparam int CBW = $clog2(IMG_W);
  localparam int WRW = $clog2(IMG_H/2);
  localparam int WCW = $clog2(IMG_W/2);
  localparam int IMW = 36*DATA_SIZE;

  localparam logic [WRW-1:0] LAST_R = WRW'((IMG_H-6)/2);
  localparam logic [WCW-1:0] LAST_C = WCW'((IMG_W-6)/2);
  localparam logic [CBW-1:0] LAST_X = CBW'(IMG_W-1);

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    REFILL
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     row_cnt_q, row_cnt_d;
  logic [2:0]     row_base_q, row_base_d;
  logic [CBW-1:0] col_cnt_q, col_cnt_d;
  logic [WRW-1:0] win_row_q, win_row_d;
  logic [WCW-1:0] win_col_q, win_col_d;
  logic [IMW-1:0] im_q, im_d;
  logic           im_vld_q, im_vld_d;
  logic           px_rdy_q, px_rdy_d;

  logic [DATA_SIZE-1:0] buf_q [6][IMG_W];

  logic           px_acc;
  logic           im_acc;
  logic           last_win;
  logic [2:0]     wr_row;
  logic [CBW-1:0] col_base;
  logic [IMW-1:0] win_w;

  function automatic logic [2:0] mod6(input logic [3:0] v);
    if (v >= 4'd6) return 3'(v - 4'd6);
    return v[2:0];
  endfunction

  assign px_acc   = bus.pxVld & px_rdy_q;
  assign im_acc   = im_vld_q & bus.imRdy;
  assign last_win = im_acc & (win_col_q == LAST_C)
                  & (win_row_q == LAST_R);
  assign wr_row   = mod6({1'b0, row_base_q} + {1'b0, row_cnt_q});
  assign col_base = CBW'({win_col_q, 1'b0});

  // Row r of the window is the r-th oldest buffered row.
  always_comb begin
    win_w = '0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        win_w[(35-6*r-c)*DATA_SIZE +: DATA_SIZE] =
          buf_q[mod6({1'b0, row_base_q} + 4'(r))]
               [col_base + CBW'(c)];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    row_base_d = row_base_q;
    col_cnt_d  = col_cnt_q;
    win_row_d  = win_row_q;
    win_col_d  = win_col_q;
    im_d       = im_q;
    im_vld_d   = im_vld_q;
    unique case (state_q)
      FILL, REFILL: begin
        if (px_acc) begin
          if (col_cnt_q == LAST_X) begin
            col_cnt_d = '0;
            if (row_cnt_q == 3'd5) begin
              row_cnt_d = '0;
              state_d   = EMIT;
            end else begin
              row_cnt_d = row_cnt_q + 3'd1;
            end
          end else begin
            col_cnt_d = col_cnt_q + CBW'(1);
          end
        end
      end
      EMIT: begin
        if (im_acc) begin
          im_vld_d = 1'b0;
          if (win_col_q == LAST_C) begin
            win_col_d = '0;
            if (win_row_q == LAST_R) begin
              state_d    = FILL;
              row_base_d = '0;
              row_cnt_d  = '0;
              win_row_d  = '0;
            end else begin
              // Two oldest rows retire; refill them.
              state_d    = REFILL;
              row_base_d = mod6({1'b0, row_base_q} + 4'd2);
              row_cnt_d  = 3'd4;
              win_row_d  = win_row_q + WRW'(1);
            end
          end else begin
            win_col_d = win_col_q + WCW'(1);
          end
        end else if (!im_vld_q) begin
          im_d     = win_w;
          im_vld_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
    px_rdy_d = (state_d != EMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      row_cnt_q  <= '0;
      row_base_q <= '0;
      col_cnt_q  <= '0;
      win_row_q  <= '0;
      win_col_q  <= '0;
      im_q       <= '0;
      im_vld_q   <= 1'b0;
      px_rdy_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      row_base_q <= row_base_d;
      col_cnt_q  <= col_cnt_d;
      win_row_q  <= win_row_d;
      win_col_q  <= win_col_d;
      im_q       <= im_d;
      im_vld_q   <= im_vld_d;
      px_rdy_q   <= px_rdy_d;
    end
  end

  // Pixel storage carries no reset; control state gates its use.
  always_ff @(posedge clk) begin
    if (px_acc) buf_q[wr_row][col_cnt_q] <= bus.px;
  end

  assign bus.pxRdy   = px_rdy_q;
  assign bus.imVld   = im_vld_q;
  assign bus.im      = im_q;
  assign bus.winRow  = win_row_q;
  assign bus.winCol  = win_col_q;
  assign bus.frmDone = last_win;
endmodule

// File: tb/tb_im_window_gen.sv
// tb_im_window_gen: directed frames with a window scoreboard.
// Ports: none; drives im_window_gen through im_window_gen_if.
module tb_im_window_gen;
  localparam int W   = 28;
  localparam int H   = 28;
  localparam int DW  = 8;
  localparam int NWR = (H-6)/2 + 1;
  localparam int NWC = (W-6)/2 + 1;

  typedef struct {
    logic [287:0] im;
    int           r;
    int           c;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  im_window_gen_if #(.IMG_W(W), .IMG_H(H), .DATA_SIZE(DW)) bus();

  im_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_SIZE(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  win_t       sb[$];
  logic [7:0] frame [H][W];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         frm_done_cnt = 0;
  int         base_done;

  task automatic chk(input string tag, input logic [287:0] obs,
                     input logic [287:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // mode 0: ramp (28r+c) mod 256, else random bytes keyed by seed.
  task automatic make_frame(input int mode, input int seed);
    win_t w;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = (mode == 0) ? 8'(W*r + c)
                                  : 8'($urandom) ^ 8'(seed);
    for (int wr = 0; wr < NWR; wr++) begin
      for (int wc = 0; wc < NWC; wc++) begin
        w.im = '0;
        w.r  = wr;
        w.c  = wc;
        for (int r = 0; r < 6; r++)
          for (int c = 0; c < 6; c++)
            w.im[287-48*r-8*c -: 8] = frame[2*wr+r][2*wc+c];
        sb.push_back(w);
      end
    end
  endtask

  task automatic ramp_spots(input int r, input int c);
    if (r == 0 && c == 0) begin
      chk("w00_b0", bus.im[287:280], 8'h00);
      chk("w00_b5", bus.im[247:240], 8'h05);
      chk("w00_b6", bus.im[239:232], 8'h1C);
      chk("w00_b35", bus.im[7:0], 8'h91);
    end
    if (r == 0 && c == 1) chk("w01_b0", bus.im[287:280], 8'h02);
    if (r == 1 && c == 0) chk("w10_b0", bus.im[287:280], 8'h38);
    if (r == NWR-1 && c == NWC-1) begin
      chk("wlast_b0", bus.im[287:280], 8'h7E);
      chk("wlast_b35", bus.im[7:0], 8'h0F);
    end
  endtask

  task automatic run_frame(input int stall_pct, input bit px_always,
                           input int abort_px, input bit ramp);
    int           pix_idx  = 0;
    int           px_since = 0;
    int           win_idx  = 0;
    int           cycles   = 0;
    bit           prev_stall = 0;
    logic [287:0] prev_im  = '0;
    logic [3:0]   prev_r   = '0;
    logic [3:0]   prev_c   = '0;
    bit           im_x, px_x;
    win_t         e;
    forever begin
      @(negedge clk);
      bus.pxVld = (pix_idx < W*H) &&
                  (px_always || $urandom_range(0, 99) < 60);
      bus.px    = (pix_idx < W*H) ? frame[pix_idx/W][pix_idx%W] : 8'h00;
      bus.imRdy = ($urandom_range(0, 99) >= stall_pct);
      #1;
      chk("px_im_excl", bus.pxRdy & bus.imVld, 1'b0);
      if (prev_stall) begin
        chk("stall_vld", bus.imVld, 1'b1);
        chk("stall_im", bus.im, prev_im);
        chk("stall_row", bus.winRow, prev_r);
        chk("stall_col", bus.winCol, prev_c);
      end
      im_x = bus.imVld & bus.imRdy;
      px_x = bus.pxVld & bus.pxRdy;
      chk("frm_done", bus.frmDone, im_x && sb.size() == 1);
      if (bus.frmDone) frm_done_cnt++;
      if (im_x) begin
        if (sb.size() == 0) begin
          chk("extra_win", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("win_im", bus.im, e.im);
          chk("win_row", bus.winRow, e.r);
          chk("win_col", bus.winCol, e.c);
          chk("px_between", px_since,
              (win_idx == 0) ? 6*W : ((e.c == 0) ? 2*W : 0));
          if (ramp) ramp_spots(e.r, e.c);
        end
        px_since = 0;
        win_idx++;
      end
      if (px_x) begin
        pix_idx++;
        px_since++;
      end
      prev_stall = bus.imVld & ~bus.imRdy;
      prev_im    = bus.im;
      prev_r     = bus.winRow;
      prev_c     = bus.winCol;
      cycles++;
      if (abort_px >= 0 && pix_idx >= abort_px) break;
      if (abort_px < 0 && sb.size() == 0) break;
      if (cycles > 20000) begin
        chk("timeout", 1'b1, 1'b0);
        break;
      end
    end
    if (abort_px < 0) begin
      chk("win_count", win_idx, NWR*NWC);
      chk("px_total", pix_idx, W*H);
    end
    @(negedge clk);
    bus.pxVld = 1'b0;
    bus.imRdy = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pxrdy"}, bus.pxRdy, 1'b0);
    chk({tag, "_imvld"}, bus.imVld, 1'b0);
    chk({tag, "_im"}, bus.im, '0);
    chk({tag, "_row"}, bus.winRow, '0);
    chk({tag, "_col"}, bus.winCol, '0);
    chk({tag, "_done"}, bus.frmDone, 1'b0);
  endtask

  initial begin
    bus.pxVld = 1'b0;
    bus.px    = '0;
    bus.imRdy = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b1;
    @(negedge clk);
    chk("pxrdy_after_rst", bus.pxRdy, 1'b1);
    chk("imvld_after_rst", bus.imVld, 1'b0);

    make_frame(0, 0);
    run_frame(0, 1'b1, -1, 1'b1);

    make_frame(0, 0);
    run_frame(50, 1'b0, -1, 1'b1);

    make_frame(0, 0);
    run_frame(0, 1'b0, 6*W + 30, 1'b1);
    chk("in_refill", bus.pxRdy, 1'b1);
    bus.pxVld = 1'b1;
    bus.imRdy = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_hold");
    bus.pxVld = 1'b0;
    bus.imRdy = 1'b0;
    rst = 1'b1;
    sb.delete();
    make_frame(0, 0);
    run_frame(30, 1'b1, -1, 1'b1);

    base_done = frm_done_cnt;
    make_frame(1, 17);
    run_frame(20, 1'b0, -1, 1'b0);
    make_frame(1, 91);
    run_frame(20, 1'b1, -1, 1'b0);
    chk("frm_done_twice", frm_done_cnt - base_done, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
